// File: rtl/miriscv_lsu_pkg.sv
// miriscv LSU shared definitions
// access size codes, sequencer states and legality check
package miriscv_lsu_pkg;

    localparam int DATA_BE_W = 4;

    localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd0;
    localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [2:0] MEM_ACCESS_WORD  = 3'd2;
    localparam logic [2:0] MEM_ACCESS_DWORD = 3'd3;
    localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;
    localparam logic [2:0] MEM_ACCESS_UHALF = 3'd5;
    localparam logic [2:0] MEM_ACCESS_UWORD = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } lsu_state_e;

    // RV32 has no doubleword/unsigned-word, and unsigned stores make no sense
    function automatic logic is_legal_access(
        input logic [2:0] size,
        input logic       we
    );
        logic bad;
        bad = (size == MEM_ACCESS_DWORD)
           || (size == MEM_ACCESS_UWORD)
           || (size == 3'd7)
           || (we && (size == MEM_ACCESS_UHALF))
           || (we && (size == MEM_ACCESS_UBYTE));
        return !bad;
    endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// miriscv LSU lane alignment
// byte mask, store-data rotation, load-data merge and extension
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [6:0]  mask,
    output logic [31:0] wdata_rot,
    output logic [31:0] rdata_ext
);

    logic [6:0]  base;
    logic [63:0] wd2;
    logic [63:0] rd2;
    logic [31:0] merged;
    logic [4:0]  sh;

    assign sh = {off, 3'b000};

    // unshifted lane pattern for the access width
    always_comb begin
        base = 7'b0;
        unique case (1'b1)
            (size == MEM_ACCESS_WORD):
                base = 7'b0001111;
            (size == MEM_ACCESS_HALF) ||
            (size == MEM_ACCESS_UHALF):
                base = 7'b0000011;
            (size == MEM_ACCESS_BYTE) ||
            (size == MEM_ACCESS_UBYTE):
                base = 7'b0000001;
            default:
                base = 7'b0;
        endcase
    end

    assign mask = base << off;

    // rotations: lanes beyond bit 31 of the window wrap to the next beat
    always_comb begin
        wd2       = {wdata, wdata} << sh;
        rd2       = {rdata, rdata} >> sh;
        wdata_rot = wd2[63:32];
        merged    = rd2[31:0];
    end

    // sign or zero extension of the merged load value
    always_comb begin
        rdata_ext = merged;
        unique case (1'b1)
            (size == MEM_ACCESS_HALF):
                rdata_ext = {{16{merged[15]}}, merged[15:0]};
            (size == MEM_ACCESS_UHALF):
                rdata_ext = {16'b0, merged[15:0]};
            (size == MEM_ACCESS_BYTE):
                rdata_ext = {{24{merged[7]}}, merged[7:0]};
            (size == MEM_ACCESS_UBYTE):
                rdata_ext = {24'b0, merged[7:0]};
            default:
                rdata_ext = merged;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu_seq.sv
// miriscv LSU bus sequencer
// splits misaligned accesses into two req/gnt/rvalid beats
module miriscv_lsu_seq
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic [2:0]           lsu_size_i,
    input  logic [ADDR_W-1:0]    lsu_addr_i,
    input  logic [XLEN-1:0]      lsu_wdata_i,
    input  logic                 lsu_kill_i,
    output logic                 lsu_busy_o,
    output logic                 lsu_done_o,
    output logic                 lsu_err_o,
    output logic [XLEN-1:0]      lsu_rdata_o,
    output logic                 data_req_o,
    output logic                 data_we_o,
    output logic [DATA_BE_W-1:0] data_be_o,
    output logic [ADDR_W-1:0]    data_addr_o,
    output logic [XLEN-1:0]      data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [XLEN-1:0]      data_rdata_i
);

    lsu_state_e state_q, state_d;

    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;
    logic              killed_q;
    logic [XLEN-1:0]   rbuf_q, rbuf_d;
    logic [XLEN-1:0]   rdata_q;

    logic [6:0]          mask;
    logic [XLEN-1:0]     wdata_rot;
    logic [XLEN-1:0]     rdata_ext;
    logic [DATA_BE_W-1:0] cap_be;
    logic                split;
    logic                in_wait;
    logic                in_req;
    logic                kill_any;
    logic [ADDR_W-1:0]   aligned;

    miriscv_lsu_align u_align (
        .size      (size_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (rbuf_d),
        .mask      (mask),
        .wdata_rot (wdata_rot),
        .rdata_ext (rdata_ext)
    );

    assign split    = |mask[6:4];
    assign in_wait  = (state_q == WAIT0) || (state_q == WAIT1);
    assign in_req   = (state_q == REQ0) || (state_q == REQ1);
    assign kill_any = killed_q || lsu_kill_i;
    assign aligned  = {addr_q[ADDR_W-1:2], 2'b00};

    // overlay the lanes of the current beat onto the gathered load word
    always_comb begin
        cap_be = '0;
        rbuf_d = rbuf_q;
        if (data_rvalid_i && state_q == WAIT0) begin
            cap_be = mask[3:0];
        end else if (data_rvalid_i && state_q == WAIT1) begin
            cap_be = {1'b0, mask[6:4]};
        end
        for (int i = 0; i < DATA_BE_W; i++) begin
            if (cap_be[i]) begin
                rbuf_d[8*i +: 8] = data_rdata_i[8*i +: 8];
            end
        end
    end

    // next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    state_d = is_legal_access(lsu_size_i, lsu_we_i)
                            ? REQ0 : DONE;
                end
            end
            REQ0: begin
                if (data_gnt_i)      state_d = WAIT0;
                else if (lsu_kill_i) state_d = IDLE;
            end
            WAIT0: begin
                if (data_rvalid_i) begin
                    if (kill_any)   state_d = IDLE;
                    else if (split) state_d = REQ1;
                    else            state_d = DONE;
                end
            end
            REQ1: begin
                if (data_gnt_i)      state_d = WAIT1;
                else if (lsu_kill_i) state_d = IDLE;
            end
            WAIT1: begin
                if (data_rvalid_i) begin
                    state_d = kill_any ? IDLE : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, captured request and gathered load data
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            killed_q <= 1'b0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && lsu_req_i) begin
                we_q     <= lsu_we_i;
                size_q   <= lsu_size_i;
                addr_q   <= lsu_addr_i;
                wdata_q  <= lsu_wdata_i;
                err_q    <= !is_legal_access(lsu_size_i, lsu_we_i);
                killed_q <= 1'b0;
                rbuf_q   <= '0;
                rdata_q  <= '0;
            end
            if (in_wait && data_rvalid_i) begin
                rbuf_q <= rbuf_d;
            end
            if (lsu_kill_i && (in_wait || (in_req && data_gnt_i))) begin
                killed_q <= 1'b1;
            end
            if (in_wait && state_d == DONE) begin
                rdata_q <= we_q ? '0 : rdata_ext;
            end
        end
    end

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_done_o   = (state_q == DONE);
    assign lsu_err_o    = (state_q == DONE) && err_q;
    assign lsu_rdata_o  = rdata_q;

    assign data_req_o   = in_req;
    assign data_we_o    = in_req && we_q;
    assign data_wdata_o = (in_req && we_q) ? wdata_rot : '0;
    assign data_addr_o  = (state_q == REQ1) ? aligned + ADDR_W'(4)
                        : (state_q == REQ0) ? aligned
                        : '0;
    assign data_be_o    = (state_q == REQ1) ? {1'b0, mask[6:4]}
                        : (state_q == REQ0) ? mask[3:0]
                        : '0;

endmodule

// File: tb/tb_miriscv_lsu_seq.sv
// miriscv LSU sequencer bench
// vector table with beat/result scoreboard plus kill/reset sequences
module tb_miriscv_lsu_seq;
    import miriscv_lsu_pkg::*;

    logic        clk_i = 0;
    logic        arstn_i = 0;
    logic        lsu_req_i = 0;
    logic        lsu_we_i = 0;
    logic [2:0]  lsu_size_i = 0;
    logic [31:0] lsu_addr_i = 0;
    logic [31:0] lsu_wdata_i = 0;
    logic        lsu_kill_i = 0;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic        lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 0;
    logic        data_rvalid_i = 0;
    logic [31:0] data_rdata_i = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    miriscv_lsu_seq #(.XLEN(32), .ADDR_W(32)) dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_size_i    (lsu_size_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_kill_i    (lsu_kill_i),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_done_o    (lsu_done_o),
        .lsu_err_o     (lsu_err_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        chk_rd;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        err;
        int          lat;
    } res_t;

    beat_t bq[$];
    res_t  rq[$];
    vec_t  vecs[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] size,
                             input logic [31:0] addr,
                             input logic [31:0] wdata);
        lsu_req_i   = 1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
    endtask

    task automatic apply(input vec_t v, input int idx);
        beat_t       b;
        res_t        r;
        int          cyc;
        int          nb;
        logic        pend;
        logic        fin;
        logic [31:0] rdv[2];
        rdv[0] = v.rd0;
        rdv[1] = v.rd1;
        if (v.nbeats > 0) begin
            b.addr = v.a0; b.be = v.be0; b.we = v.we; b.wd = v.wd;
            bq.push_back(b);
        end
        if (v.nbeats > 1) begin
            b.addr = v.a1; b.be = v.be1; b.we = v.we; b.wd = v.wd;
            bq.push_back(b);
        end
        r.rd = v.exp_rd; r.chk_rd = v.chk_rd;
        r.err = v.exp_err; r.lat = v.lat;
        rq.push_back(r);
        @(negedge clk_i);
        drive_req(v.we, v.size, v.addr, v.wdata);
        @(negedge clk_i);
        lsu_req_i = 0;
        cyc = 1; nb = 0; pend = 0; fin = 0;
        while (!fin && cyc <= 20) begin
            data_gnt_i = 0;
            data_rvalid_i = 0;
            if (pend) begin
                data_rvalid_i = 1;
                data_rdata_i = rdv[(nb > 1) ? 1 : 0];
                pend = 0;
            end else if (data_req_o) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d_extra_beat: got addr %h want none",
                             idx, data_addr_o);
                end else begin
                    b = bq.pop_front();
                    chk($sformatf("v%0d_addr", idx), data_addr_o, b.addr);
                    chk($sformatf("v%0d_be", idx), 32'(data_be_o),
                        32'(b.be));
                    chk($sformatf("v%0d_we", idx), 32'(data_we_o),
                        32'(b.we));
                    if (b.we)
                        chk($sformatf("v%0d_wdata", idx), data_wdata_o,
                            b.wd);
                end
                data_gnt_i = 1;
                pend = 1;
                nb++;
            end
            if (lsu_done_o) begin
                r = rq.pop_front();
                chk($sformatf("v%0d_err", idx), 32'(lsu_err_o),
                    32'(r.err));
                chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(r.lat));
                chk($sformatf("v%0d_beats_left", idx), 32'(bq.size()), 0);
                if (r.chk_rd)
                    chk($sformatf("v%0d_rdata", idx), lsu_rdata_o, r.rd);
                fin = 1;
            end
            @(negedge clk_i);
            cyc++;
        end
        data_gnt_i = 0;
        data_rvalid_i = 0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: got no done want done", idx);
            bq.delete();
            rq.delete();
        end
        chk($sformatf("v%0d_done_pulse", idx), 32'(lsu_done_o), 0);
        chk($sformatf("v%0d_idle", idx), 32'(lsu_busy_o), 0);
    endtask

    initial begin
        // we size addr wdata rd0 rd1 nb a0 be0 a1 be1 wd exp chk err lat
        vecs[0]  = '{0, MEM_ACCESS_WORD, 'h100, 0, 'hDEADBEEF, 0,
                     1, 'h100, 4'hF, 0, 0, 0, 'hDEADBEEF, 1, 0, 3};
        vecs[1]  = '{0, MEM_ACCESS_HALF, 'h103, 0, 'h80123456, 'h789ABCFF,
                     2, 'h100, 4'h8, 'h104, 4'h1, 0, 'hFFFFFF80, 1, 0, 5};
        vecs[2]  = '{1, MEM_ACCESS_WORD, 'h002, 'h11223344, 0, 0,
                     2, 'h000, 4'hC, 'h004, 4'h3, 'h33441122, 0, 0, 0, 5};
        vecs[3]  = '{0, MEM_ACCESS_UBYTE, 'h001, 0, 'h00009A00, 0,
                     1, 'h000, 4'h2, 0, 0, 0, 'h0000009A, 1, 0, 3};
        vecs[4]  = '{0, MEM_ACCESS_BYTE, 'h001, 0, 'h00009A00, 0,
                     1, 'h000, 4'h2, 0, 0, 0, 'hFFFFFF9A, 1, 0, 3};
        vecs[5]  = '{1, MEM_ACCESS_UBYTE, 'h010, 'h55, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[6]  = '{0, MEM_ACCESS_DWORD, 'h020, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[7]  = '{1, MEM_ACCESS_DWORD, 'h024, 'h77, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{0, MEM_ACCESS_WORD, 'hFFFFFFFE, 0, 'hAABB0000,
                     'h0000DDCC, 2, 'hFFFFFFFC, 4'hC, 'h0, 4'h3, 0,
                     'hDDCCAABB, 1, 0, 5};
        vecs[9]  = '{0, MEM_ACCESS_UHALF, 'h102, 0, 'h80010000, 0,
                     1, 'h100, 4'hC, 0, 0, 0, 'h00008001, 1, 0, 3};
        vecs[10] = '{0, MEM_ACCESS_HALF, 'h102, 0, 'h80010000, 0,
                     1, 'h100, 4'hC, 0, 0, 0, 'hFFFF8001, 1, 0, 3};
        vecs[11] = '{1, MEM_ACCESS_HALF, 'h101, 'h1234ABCD, 0, 0,
                     1, 'h100, 4'h6, 0, 0, 'h34ABCD12, 0, 0, 0, 3};
        vecs[12] = '{1, MEM_ACCESS_BYTE, 'h003, 'h000000EE, 0, 0,
                     1, 'h000, 4'h8, 0, 0, 'hEE000000, 0, 0, 0, 3};
        vecs[13] = '{0, MEM_ACCESS_HALF, 'h103, 0, 'h7F000000, 'h00000001,
                     2, 'h100, 4'h8, 'h104, 4'h1, 0, 'h0000017F, 1, 0, 5};
        vecs[14] = '{1, MEM_ACCESS_UHALF, 'h040, 'h1, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[15] = '{0, 3'd7, 'h044, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[16] = '{0, MEM_ACCESS_WORD, 'h105, 0, 'h33221100, 'h00000044,
                     2, 'h104, 4'hE, 'h108, 4'h1, 0, 'h44332211, 1, 0, 5};
        vecs[17] = '{0, MEM_ACCESS_UWORD, 'h048, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(lsu_busy_o), 0);
        chk("rst_req", 32'(data_req_o), 0);
        chk("rst_done", 32'(lsu_done_o), 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        arstn_i = 1;
        @(negedge clk_i);

        for (int i = 0; i < 18; i++) apply(vecs[i], i);

        // kill in REQ0 while grant is withheld
        drive_req(0, MEM_ACCESS_WORD, 'h200, 0);
        @(negedge clk_i);
        lsu_req_i = 0;
        chk("kreq_req_on", 32'(data_req_o), 1);
        lsu_kill_i = 1;
        @(negedge clk_i);
        lsu_kill_i = 0;
        chk("kreq_req_off", 32'(data_req_o), 0);
        chk("kreq_idle", 32'(lsu_busy_o), 0);
        for (int i = 0; i < 3; i++) begin
            chk("kreq_no_done", 32'(lsu_done_o), 0);
            @(negedge clk_i);
        end

        // kill in WAIT0 of a split load: no second beat, no done
        drive_req(0, MEM_ACCESS_WORD, 'h101, 0);
        @(negedge clk_i);
        lsu_req_i = 0;
        chk("kwait_req_on", 32'(data_req_o), 1);
        data_gnt_i = 1;
        @(negedge clk_i);
        data_gnt_i = 0;
        lsu_kill_i = 1;
        @(negedge clk_i);
        lsu_kill_i = 0;
        chk("kwait_still_busy", 32'(lsu_busy_o), 1);
        data_rvalid_i = 1;
        data_rdata_i = 'h12345678;
        @(negedge clk_i);
        data_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("kwait_no_req", 32'(data_req_o), 0);
            chk("kwait_no_done", 32'(lsu_done_o), 0);
            @(negedge clk_i);
        end
        chk("kwait_idle", 32'(lsu_busy_o), 0);

        // a request presented during DONE must not be taken
        drive_req(1, MEM_ACCESS_UBYTE, 'h050, 0);
        @(negedge clk_i);
        chk("dn_done", 32'(lsu_done_o), 1);
        drive_req(0, MEM_ACCESS_WORD, 'h400, 0);
        @(negedge clk_i);
        lsu_req_i = 0;
        chk("dn_not_sampled", 32'(lsu_busy_o), 0);
        chk("dn_no_req", 32'(data_req_o), 0);

        // asynchronous reset while waiting for the response
        @(negedge clk_i);
        drive_req(0, MEM_ACCESS_WORD, 'h300, 0);
        @(negedge clk_i);
        lsu_req_i = 0;
        data_gnt_i = 1;
        @(negedge clk_i);
        data_gnt_i = 0;
        chk("rw_busy", 32'(lsu_busy_o), 1);
        arstn_i = 0;
        #1;
        chk("rw_busy0", 32'(lsu_busy_o), 0);
        chk("rw_req0", 32'(data_req_o), 0);
        chk("rw_be0", 32'(data_be_o), 0);
        chk("rw_addr0", data_addr_o, 0);
        chk("rw_rdata0", lsu_rdata_o, 0);
        chk("rw_done0", 32'(lsu_done_o), 0);
        @(negedge clk_i);
        arstn_i = 1;
        apply(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miriscv_lsu_seq.md
Name: miriscv_lsu_seq

Overview:
- Sequencer between the core's load/store stage and the single data-memory port (req/gnt/rvalid protocol).
- Accepts one access per transaction, sized by the MEM_ACCESS_* codes.
- Splits misaligned word/half accesses into two aligned bus beats; generates byte enables; merges load data and sign/zero-extends it.
- Supports RV32 only; flags illegal size codes.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- ADDR_W, 32, bus address width.

Ports:
- clk_i  in  1  core clock
- arstn_i  in  1  reset, asynchronous, active-low
- lsu_req_i  in  1  access request; sampled only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  3  MEM_ACCESS_* code
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, right-aligned
- lsu_kill_i  in  1  abort current access (pipeline flush)
- lsu_busy_o  out  1  high in every state except IDLE
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_err_o  out  1  illegal access; valid with lsu_done_o
- lsu_rdata_o  out  32  extended load data; valid with lsu_done_o
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word-aligned bus address
- data_wdata_o  out  32  lane-rotated store data
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid (loads and stores)
- data_rdata_i  in  32  bus read data

Behaviour:
- Reset (arstn_i low, asynchronous): state = IDLE. All outputs 0; lsu_rdata_o = 0.
- IDLE:
  - When lsu_req_i = 1, register we/size/addr/wdata.
  - off = addr[1:0].
  - split = (WORD and off != 0) or (HALF/UHALF and off = 3).
  - Illegal = size in {DWORD, UWORD, 7}, or a store with UHALF/UBYTE. Illegal goes to DONE with err = 1 and no bus activity.
  - Legal goes to REQ0.
- REQ0:
  - data_req_o = 1, addr = {addr[31:2], 2'b00}.
  - Mask m = (1111 for word / 0011 for half / 0001 for byte) << off, over 7 bits. be0 = m[3:0].
  - On data_gnt_i go to WAIT0. Bus outputs hold stable until gnt.
- WAIT0:
  - On data_rvalid_i, capture the be0 lanes of rdata.
  - If split, go to REQ1; else go to DONE.
- REQ1:
  - addr = aligned + 4, with 32-bit wrap (0xFFFF_FFFC → 0x0000_0000).
  - be1 = m[6:4] zero-extended to 4 bits.
  - On data_gnt_i go to WAIT1.
- WAIT1: on data_rvalid_i, capture the be1 lanes, then go to DONE.
- DONE:
  - lsu_done_o = 1 for exactly one cycle, then return to IDLE.
  - A new lsu_req_i in this cycle is not sampled.
- Store data: data_wdata_o = wdata rotated left by 8*off, used for both beats.
- Load data:
  - Merged word = beat1 lanes over beat0 lanes, rotated right by 8*off.
  - WORD: as-is. HALF/BYTE: sign-extend. UHALF/UBYTE: zero-extend.
  - Result registered into lsu_rdata_o on DONE entry.
- Protocol:
  - One outstanding transaction only.
  - rvalid arrives no earlier than the cycle after gnt.
  - rvalid outside WAIT0/WAIT1 is ignored.
- Latency: aligned access with gnt in the first REQ cycle and rvalid one cycle later gives done 3 cycles after the request was sampled. Split access gives 5.
- Kill:
  - In REQ0/REQ1 before gnt: drop data_req_o next cycle, go to IDLE, no done.
  - In WAIT0/WAIT1: set a kill flag, wait for rvalid, go to IDLE, no done, no second beat.
  - A killed split store may leave beat0 written; this is accepted.
  - Kill in IDLE/DONE is ignored.
- Reset mid-transaction: immediate return to IDLE with outputs 0. Any outstanding bus response is dropped by the memory reset.

Decomposition:
- miriscv_lsu_pkg gains:
  - the state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE);
  - the DATA_BE_W = 4 constant;
  - an is_legal_access(size, we) function.
- Sub-module miriscv_lsu_align (combinational): takes size/off/wdata/merged rdata and produces the mask, rotated wdata and extended rdata. The FSM stays in miriscv_lsu_seq.

Test Plan:
- Aligned LW, addr 0x100, rdata 0xDEADBEEF → one beat, be 1111, addr 0x100, done at cycle 3, rdata 0xDEADBEEF.
- LH, addr 0x103 (split):
  - beat0: addr 0x100, be 1000, rdata 0x80xxxxxx;
  - beat1: addr 0x104, be 0001, rdata 0xxxxxxxFF;
  - result: rdata 0xFFFF_FF80.
- SW 0x11223344 to addr 0x002 → beat0 be 1100, beat1 be 0011 at 0x004, wdata 0x33441122 on both beats.
- LBU addr 0x001, rdata 0x0000_9A00 → rdata 0x0000_009A. LB on the same access → 0xFFFF_FF9A.
- Store with UBYTE, or any DWORD → no data_req_o, done + err 1 cycle after sampling. Kill in REQ0 with gnt low → IDLE, no done.
- Split LW at 0xFFFF_FFFE → beat1 addr 0x0000_0000. Assert arstn_i low in WAIT0 → all outputs 0 immediately, state IDLE.
